kl_batchmean_reduce: RTL
========================

# kl_batchmean_reduce

Streaming reduction stage that sits directly downstream of the KL-divergence element stage. It consumes per-element KL terms (signed Q16.16), accumulates them over one tensor, and divides the sum by a runtime batch size to produce the `batchmean` loss scalar. The division is a multi-cycle sequential divider. Results leave through a valid/ready handshake to the loss-output consumer.

## Interface
- `DATA_W`, 32: width of input terms and of the result (signed, Q16.16).
- `ACC_W`, 48: accumulator width (signed). Must satisfy ACC_W > DATA_W.
- `CNT_W`, 16: batch_size width.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_in` in 1: input beat valid.
- `ready_in` out 1: block can accept a beat.
- `last_in` in 1: marks the final term of the tensor; qualified by the input handshake.
- `input_data` in DATA_W: per-element KL term, signed Q16.16.
- `batch_size` in CNT_W: unsigned divisor, sampled on the last-beat handshake.
- `valid_out` out 1: result valid.
- `ready_out` in 1: consumer accepts the result.
- `output_data` out DATA_W: batchmean result, signed Q16.16.
- `sat_out` out 1: saturation occurred in the accumulator or on the result (sticky per tensor).
- `div0_out` out 1: batch_size was 0.

## Operation
- States:
  - ACCUM: `ready_in` = 1.
  - DIVIDE: `ready_in` = 0.
  - OUTPUT: `ready_in` = 0, `valid_out` = 1.
- Input handshake is `valid_in && ready_in`. `last_in` and `batch_size` are ignored when the handshake is absent.
- ACCUM, each accepted beat:
  - `acc <= sat(acc + sext(input_data))`.
  - Clamp to ±(2^(ACC_W-1)) limits. Any clamp sets the sticky `sat`.
- ACCUM, accepted beat with `last_in` = 1:
  - The beat is accumulated.
  - `batch_size` is latched.
  - If latched `batch_size` = 0: result = 0, div0 = 1, go to OUTPUT.
  - Otherwise go to DIVIDE.
- DIVIDE:
  - Divide |acc| by the batch_size with unsigned restoring division, one quotient bit per cycle, ACC_W cycles.
  - Apply the dividend sign to the quotient. Rounding is truncation toward zero.
  - If the quotient is outside the DATA_W signed range, clamp to 0x7FFF_FFFF or 0x8000_0000 and set `sat`.
- OUTPUT:
  - `output_data`, `sat_out` and `div0_out` are held stable while `valid_out` = 1 && `ready_out` = 0.
  - On the output handshake: clear acc, sat and div0, then go to ACCUM.
- Empty tensor: a single beat with `last_in` = 1 is the minimum tensor. There is no zero-length tensor.
- Reset in any state:
  - Next state is ACCUM; the partial sum and any in-flight division are discarded.
  - `valid_out` = 0.

## Timing
- Reset values: `ready_in` = 1, `valid_out` = 0, `output_data` = 0, `sat_out` = 0, `div0_out` = 0, acc = 0.
- Throughput in ACCUM: one beat per cycle, with no bubbles between beats.
- Latency, with the last beat accepted at cycle T:
  - DIVIDE occupies T+1 .. T+ACC_W.
  - `valid_out` rises at T+ACC_W+1 (T+49 at defaults).
  - If batch_size = 0, `valid_out` rises at T+1.
- Output handshake at cycle H:
  - `valid_out` = 0 and `ready_in` = 1 at H+1.
  - The first beat of the next tensor can be accepted at H+1.
- `valid_out` never drops without a handshake, except on `rst`.
- Outputs are registered. There is no combinational path from `ready_out` to `ready_in`.

## Test plan
- Basic: 4 beats of 0x0001_0000, `last_in` on beat 4, batch_size 2 -> `output_data` = 0x0002_0000, sat = 0, div0 = 0, `valid_out` exactly 49 cycles after the last accept.
- Sign and truncation:
  - One beat 0xFFFD_0000, batch 2 -> 0xFFFE_8000.
  - One beat 0x0000_0001, batch 2 -> 0x0000_0000.
  - One beat 0xFFFF_FFFF, batch 2 -> 0x0000_0000.
- Divide by zero: 3 beats of 0x0001_0000, batch_size 0 -> `output_data` = 0, `div0_out` = 1, `valid_out` at T+1.
- Backpressure:
  - Hold `ready_out` = 0 for 10 cycles in OUTPUT -> outputs stable and `ready_in` = 0.
  - `valid_in` pulses during this window are not accepted.
  - After release, the next tensor is accumulated from zero.
- Saturation: 3 beats of 0x7FFF_FFFF, batch 1 -> `output_data` = 0x7FFF_FFFF, `sat_out` = 1. The next tensor reports sat = 0.
- Reset mid-operation:
  - Assert `rst` for 1 cycle in the middle of DIVIDE -> `valid_out` = 0 and `ready_in` = 1 on the following cycle.
  - A subsequent tensor (2 × 0x0003_0000, batch 3) -> 0x0002_0000.

Source files
------------

// File: rtl/kl_batchmean_reduce.sv
// Batchmean reduction: saturating accumulation of signed KL terms, then a
// restoring divide by the runtime batch size, with the result held until the consumer accepts it.
module kl_batchmean_reduce #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid_in,
    output logic              o_ready_in,
    input  logic              i_last_in,
    input  logic [DATA_W-1:0] i_input_data,
    input  logic [CNT_W-1:0]  i_batch_size,
    output logic              o_valid_out,
    input  logic              i_ready_out,
    output logic [DATA_W-1:0] o_output_data,
    output logic              o_sat_out,
    output logic              o_div0_out,
    output logic [1:0]        o_state
);
    // Handshakes: a beat moves when valid and ready are both high at a rising
    // edge; valid, once raised, holds with its data stable until that happens.
    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    localparam int CW = $clog2(ACC_W + 1);
    localparam logic [ACC_W-1:0]  ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0]  Q_POS_LIM = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  Q_NEG_LIM = {{(ACC_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] RES_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] RES_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    state_t             r_state, w_next;
    logic [ACC_W-1:0]   r_acc;
    logic               r_sat, r_div0, r_neg;
    logic [DATA_W-1:0]  r_out;
    logic [CNT_W-1:0]   r_bs, r_rem;
    logic [ACC_W-1:0]   r_dvd;
    logic [CW-1:0]      r_cnt;

    logic               w_accept, w_acc_ovf, w_ge, w_div_done, w_res_sat;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_acc_sat, w_abs, w_quo;
    logic [CNT_W:0]     w_trial;
    logic [CNT_W-1:0]   w_rem_nxt;
    logic [DATA_W-1:0]  w_q_neg, w_res;

    assign w_accept  = (r_state == ST_ACCUM) && i_valid_in;
    // One guard bit: overflow shows as disagreement between the top two bits.
    assign w_sum     = {r_acc[ACC_W-1], r_acc}
                     + {{(ACC_W+1-DATA_W){i_input_data[DATA_W-1]}}, i_input_data};
    assign w_acc_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_acc_sat = w_acc_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];
    assign w_abs     = w_acc_sat[ACC_W-1] ? -w_acc_sat : w_acc_sat;

    // Remainder stays below the divisor, so the modular subtract is exact.
    assign w_trial    = {r_rem, r_dvd[ACC_W-1]};
    assign w_ge       = w_trial >= {1'b0, r_bs};
    assign w_rem_nxt  = w_ge ? (w_trial[CNT_W-1:0] - r_bs) : w_trial[CNT_W-1:0];
    assign w_quo      = {r_dvd[ACC_W-2:0], w_ge};
    assign w_div_done = (r_state == ST_DIVIDE) && (r_cnt == CW'(ACC_W - 1));

    assign w_res_sat  = r_neg ? (w_quo > Q_NEG_LIM) : (w_quo > Q_POS_LIM);
    assign w_q_neg    = -w_quo[DATA_W-1:0];
    assign w_res      = w_res_sat ? (r_neg ? RES_MIN : RES_MAX)
                                  : (r_neg ? w_q_neg : w_quo[DATA_W-1:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_ACCUM;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && i_last_in)
                    w_next = (i_batch_size == '0) ? ST_OUTPUT : ST_DIVIDE;
            end
            ST_DIVIDE: if (w_div_done) w_next = ST_OUTPUT;
            ST_OUTPUT: if (i_ready_out) w_next = ST_ACCUM;
            default:   w_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc  <= '0;
            r_sat  <= 1'b0;
            r_div0 <= 1'b0;
            r_neg  <= 1'b0;
            r_out  <= '0;
            r_bs   <= '0;
            r_rem  <= '0;
            r_dvd  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_sat;
                        if (w_acc_ovf) r_sat <= 1'b1;
                        if (i_last_in) begin
                            r_bs  <= i_batch_size;
                            r_dvd <= w_abs;
                            r_rem <= '0;
                            r_cnt <= '0;
                            r_neg <= w_acc_sat[ACC_W-1];
                            if (i_batch_size == '0) begin
                                r_out  <= '0;
                                r_div0 <= 1'b1;
                            end
                        end
                    end
                end
                ST_DIVIDE: begin
                    r_dvd <= w_quo;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_div_done) begin
                        r_out <= w_res;
                        if (w_res_sat) r_sat <= 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (i_ready_out) begin
                        r_acc  <= '0;
                        r_sat  <= 1'b0;
                        r_div0 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready_in    = (r_state == ST_ACCUM);
    assign o_valid_out   = (r_state == ST_OUTPUT);
    assign o_output_data = r_out;
    assign o_sat_out     = r_sat;
    assign o_div0_out    = r_div0;
    assign o_state       = r_state;
endmodule
